// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing and signed
// saturation limits for an arbitrary operand width (up to 64 bits).
package pipelined_adder_pkg;

  // Bits handled by each pipeline stage.
  function automatic int chunk_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Largest positive two's-complement value of a w-bit word (0x7F..F).
  function automatic logic [63:0] smax(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative two's-complement value of a w-bit word (0x80..0).
  function automatic logic [63:0] smin(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One CHUNK-bit slice of the pipelined adder with its output registers:
// sum slice, carry out, carry into the slice MSB and the slot valid bit.
// Only the valid bit is reset; data registers just follow the pipeline.
module adder_stage #(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv_i,
  input  logic             vld_i,
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o,
  output logic             cmsb_o,
  output logic             vld_o
);

  logic [CHUNK:0]   full_d;
  logic             cmsb_d;
  logic [CHUNK-1:0] sum_q;
  logic             cout_q;
  logic             cmsb_q;
  logic             vld_q;

  assign full_d = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, c_i};
  // Carry into the MSB recovered from the MSB sum bit; equals c_i when CHUNK=1.
  assign cmsb_d = full_d[CHUNK-1] ^ a_i[CHUNK-1] ^ b_i[CHUNK-1];

  // Slice result registers advance with the whole pipeline.
  always_ff @(posedge clk) begin
    if (adv_i) begin
      sum_q  <= full_d[CHUNK-1:0];
      cout_q <= full_d[CHUNK];
      cmsb_q <= cmsb_d;
    end
  end

  // Slot valid: cleared by reset so in-flight beats are discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= 1'b0;
    end else if (adv_i) begin
      vld_q <= vld_i;
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;
  assign cmsb_o = cmsb_q;
  assign vld_o  = vld_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder: carry ripples one CHUNK per clock through
// STAGES adder_stage slices, with a global-stall valid/ready handshake.
// Optional feature macro: PIPELINED_ADDER_SAT_EN enables signed
// saturation of the final sum (cout/ovf still report the raw result).
// WIDTH must be a multiple of STAGES, with 1 <= STAGES <= WIDTH.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_w(WIDTH, STAGES);

  logic             adv;
  logic [WIDTH-1:0] sum_wrap;
  logic [WIDTH-1:0] sum_res;
  logic             cout_raw;
  logic             ovf_raw;

  // Whole pipeline moves together unless a held result is not taken.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !reset;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * CHUNK;
    localparam int HI = WIDTH - LO - CHUNK;

    logic [CHUNK-1:0]    a_ch;
    logic [CHUNK-1:0]    b_ch;
    logic                c_in;
    logic                v_in;
    logic [CHUNK-1:0]    sl_q;
    logic                c_q;
    logic                cm_q;
    logic                v_q;
    logic [LO+CHUNK-1:0] acc;

    if (k == 0) begin : g_first
      assign a_ch = a[CHUNK-1:0];
      assign b_ch = b[CHUNK-1:0];
      assign c_in = cin;
      assign v_in = in_valid;
      assign acc  = sl_q;
    end else begin : g_next
      logic [LO-1:0] lo_q;

      assign a_ch = g_stg[k-1].g_up.a_up_q[CHUNK-1:0];
      assign b_ch = g_stg[k-1].g_up.b_up_q[CHUNK-1:0];
      assign c_in = g_stg[k-1].c_q;
      assign v_in = g_stg[k-1].v_q;

      // Stage boundary: carry forward the sum bits already produced below this chunk.
      always_ff @(posedge clk) begin
        if (adv) begin
          lo_q <= g_stg[k-1].acc;
        end
      end

      assign acc = {sl_q, lo_q};
    end

    if (HI > 0) begin : g_up
      logic [HI-1:0] a_up_q;
      logic [HI-1:0] b_up_q;

      if (k == 0) begin : g_src_in
        // Stage boundary: park the operand chunks not yet consumed.
        always_ff @(posedge clk) begin
          if (adv) begin
            a_up_q <= a[WIDTH-1 -: HI];
            b_up_q <= b[WIDTH-1 -: HI];
          end
        end
      end else begin : g_src_prev
        // Stage boundary: drop the chunk this stage consumed, keep the rest.
        always_ff @(posedge clk) begin
          if (adv) begin
            a_up_q <= g_stg[k-1].g_up.a_up_q[CHUNK +: HI];
            b_up_q <= g_stg[k-1].g_up.b_up_q[CHUNK +: HI];
          end
        end
      end
    end

    adder_stage #(
      .CHUNK(CHUNK)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .adv_i (adv),
      .vld_i (v_in),
      .a_i   (a_ch),
      .b_i   (b_ch),
      .c_i   (c_in),
      .sum_o (sl_q),
      .cout_o(c_q),
      .cmsb_o(cm_q),
      .vld_o (v_q)
    );
  end

  assign out_valid = g_stg[STAGES-1].v_q;
  assign sum_wrap  = g_stg[STAGES-1].acc;
  assign cout_raw  = g_stg[STAGES-1].c_q;
  assign ovf_raw   = g_stg[STAGES-1].cm_q ^ g_stg[STAGES-1].c_q;

`ifdef PIPELINED_ADDER_SAT_EN
  // On signed overflow both operand signs agree and the wrapped MSB is
  // their complement, so a set wrapped MSB means a positive overflow.
  function automatic logic [WIDTH-1:0] sat_sum(input logic [WIDTH-1:0] s,
                                               input logic              o);
    if (!o) return s;
    return s[WIDTH-1] ? WIDTH'(smax(WIDTH)) : WIDTH'(smin(WIDTH));
  endfunction

  assign sum_res = sat_sum(sum_wrap, ovf_raw);
`else
  assign sum_res = sum_wrap;
`endif

  // Empty output slots (including right after reset) present zeros.
  assign sum  = out_valid ? sum_res : '0;
  assign cout = out_valid && cout_raw;
  assign ovf  = out_valid && ovf_raw;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: main instance WIDTH=16/STAGES=4,
// plus STAGES=1 and STAGES=16 instances for a random configuration sweep.
module tb_pipelined_adder;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic         reset, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;

  logic         sw_valid, sw_cin, sw_ready;
  logic [W-1:0] sw_a, sw_b;
  logic         in_ready1, out_valid1, cout1, ovf1;
  logic         in_ready16, out_valid16, cout16, ovf16;
  logic [W-1:0] sum1, sum16;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           t;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q16[$];

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [W-1:0] OVF_SUM = 16'h7FFF;
`else
  localparam logic [W-1:0] OVF_SUM = 16'h8000;
`endif

  pipelined_adder #(.WIDTH(W), .STAGES(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  pipelined_adder #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(in_ready1),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(out_valid1), .out_ready(sw_ready),
    .sum(sum1), .cout(cout1), .ovf(ovf1));

  pipelined_adder #(.WIDTH(W), .STAGES(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(sw_valid), .in_ready(in_ready16),
    .a(sw_a), .b(sw_b), .cin(sw_cin), .out_valid(out_valid16), .out_ready(sw_ready),
    .sum(sum16), .cout(cout16), .ovf(ovf16));

  // Reference: plain (W+1)-bit addition, signed overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input int t);
    logic [W:0] f;
    exp_t       e;
    f   = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    e.s = f[W-1:0];
    e.c = f[W];
    e.o = (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
`ifdef PIPELINED_ADDER_SAT_EN
    if (e.o) e.s = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
    e.t = t;
    return e;
  endfunction

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      n_tests += 5;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      if (sum !== 16'h0000) begin n_fail++; $display("FAIL rst_sum: got %h want 0000", sum); end
      if (cout !== 1'b0) begin n_fail++; $display("FAIL rst_cout: got %b want 0", cout); end
      if (ovf !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %b want 0", ovf); end
    end
    reset = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_beat: out_valid got %b want 0 (cycle %0d)", out_valid, i); end
    end
  endtask

  // Single beat through the 4-stage pipe: value and exact latency.
  task automatic test_beat(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    int got;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = x; b = y; cin = ci; #1;
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL %s_accept: in_ready got %b want 1", nm, in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    got = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i > 1) @(negedge clk);
      #1;
      if (out_valid === 1'b1 && got == 0) begin
        got = i;
        n_tests += 3;
        if (sum !== es) begin n_fail++; $display("FAIL %s_sum: got %h want %h", nm, sum, es); end
        if (cout !== ec) begin n_fail++; $display("FAIL %s_cout: got %b want %b", nm, cout, ec); end
        if (ovf !== eo) begin n_fail++; $display("FAIL %s_ovf: got %b want %b", nm, ovf, eo); end
      end
    end
    n_tests++;
    if (got != 4) begin n_fail++; $display("FAIL %s_latency: got %0d edges want 4", nm, got); end
  endtask

  task automatic test_wrap;
    test_beat("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_overflow;
    test_beat("ovf", 16'h7FFF, 16'h0001, 1'b0, OVF_SUM, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure;
    int   sent, recv;
    exp_t e;
    q4.delete();
    sent = 0; recv = 0;
    for (int cy = 0; cy < 80 && recv < 8; cy++) begin
      @(negedge clk);
      out_ready = !(cy >= 4 && cy < 7);
      if (sent < 8) begin
        in_valid = 1'b1; a = 16'(sent); b = 16'(16'h1000 * sent); cin = sent[0];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid === 1'b1) begin
        if (q4.size() == 0) begin
          n_tests++; n_fail++; $display("FAIL bp_extra: unexpected sum %h", sum);
        end else begin
          e = q4[0];
          n_tests += 3;
          if (sum !== e.s) begin n_fail++; $display("FAIL bp_sum: got %h want %h (ready=%b)", sum, e.s, out_ready); end
          if (cout !== e.c) begin n_fail++; $display("FAIL bp_cout: got %b want %b", cout, e.c); end
          if (ovf !== e.o) begin n_fail++; $display("FAIL bp_ovf: got %b want %b", ovf, e.o); end
          if (out_ready) begin
            void'(q4.pop_front());
            recv++;
          end else begin
            n_tests++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: in_ready got %b want 0", in_ready); end
          end
        end
      end
      if (in_valid && in_ready) begin
        q4.push_back(model(a, b, cin, cyc));
        sent++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_tests++;
    if (recv != 8 || q4.size() != 0) begin
      n_fail++; $display("FAIL bp_count: received %0d left %0d want 8 and 0", recv, q4.size());
    end
  endtask

  task automatic test_reset_midflight;
    q4.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'(16'h0101 * (i + 1)); b = 16'h0F0F; cin = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk); #1;
    n_tests += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", in_ready); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_stale: out_valid got %b sum %h want no beat", out_valid, sum); end
    end
  endtask

  task automatic test_sweep;
    exp_t e;
    q1.delete(); q16.delete();
    sw_ready = 1'b1;
    for (int cy = 0; cy < 1040; cy++) begin
      @(negedge clk);
      if (cy < 1000) begin
        sw_valid = 1'b1; sw_a = 16'($urandom); sw_b = 16'($urandom); sw_cin = 1'($urandom);
      end else begin
        sw_valid = 1'b0;
      end
      #1;
      if (out_valid1 === 1'b1) begin
        n_tests++;
        if (q1.size() == 0) begin
          n_fail++; $display("FAIL s1_extra: unexpected sum %h", sum1);
        end else begin
          e = q1.pop_front();
          if ({cout1, sum1, ovf1} !== {e.c, e.s, e.o} || cyc - e.t != 1) begin
            n_fail++;
            $display("FAIL s1_beat: got c=%b s=%h o=%b lat=%0d want c=%b s=%h o=%b lat=1",
                     cout1, sum1, ovf1, cyc - e.t, e.c, e.s, e.o);
          end
        end
      end
      if (out_valid16 === 1'b1) begin
        n_tests++;
        if (q16.size() == 0) begin
          n_fail++; $display("FAIL s16_extra: unexpected sum %h", sum16);
        end else begin
          e = q16.pop_front();
          if ({cout16, sum16, ovf16} !== {e.c, e.s, e.o} || cyc - e.t != 16) begin
            n_fail++;
            $display("FAIL s16_beat: got c=%b s=%h o=%b lat=%0d want c=%b s=%h o=%b lat=16",
                     cout16, sum16, ovf16, cyc - e.t, e.c, e.s, e.o);
          end
        end
      end
      if (sw_valid && in_ready1)  q1.push_back(model(sw_a, sw_b, sw_cin, cyc));
      if (sw_valid && in_ready16) q16.push_back(model(sw_a, sw_b, sw_cin, cyc));
    end
    n_tests++;
    if (q1.size() != 0 || q16.size() != 0) begin
      n_fail++; $display("FAIL sweep_drain: left %0d and %0d want 0 and 0", q1.size(), q16.size());
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    sw_valid = 1'b0; sw_ready = 1'b1; sw_a = '0; sw_b = '0; sw_cin = 1'b0;
    test_reset();
    test_wrap();
    test_overflow();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
